// File: rtl/sqr_param_extract.sv
// -----------------------------------------------------------------------------
// sqr_param_extract
//   Inverse of the square-wave table generator. Captures a 512-sample frame,
//   averages each 256-sample half, and recovers the high-level amplitude, the
//   polarity (which half holds the high level) and a symmetry error against
//   the ideal relationship low = 256 - high.
//
// Ports
//   clk        in   single clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   start      in   one-cycle pulse, arms (or restarts) a frame capture
//   din_valid  in   qualifies din during capture
//   din        in   unsigned sample, DATA_WIDTH bits
//   busy       out  high while capturing or calculating
//   done       out  one-cycle pulse, results valid from this cycle on
//   amplitude  out  recovered high-level amplitude
//   sel_signal out  0 = high level in first half, 1 = high level in second half
//   sym_err    out  |m0 + m1 - 256|, DATA_WIDTH+1 bits
//   mismatch   out  sym_err > SYM_TOL
// -----------------------------------------------------------------------------
module sqr_param_extract #(
    parameter int DATA_WIDTH = 8,
    parameter int SYM_TOL    = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  din_valid,
    input  logic [DATA_WIDTH-1:0] din,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] amplitude,
    output logic                  sel_signal,
    output logic [DATA_WIDTH:0]   sym_err,
    output logic                  mismatch
);

    // 256 samples per half: the mean is simply the upper bits of the sum.
    localparam int SUM_W = DATA_WIDTH + 8;
    localparam logic [DATA_WIDTH:0] MID = {1'b1, {DATA_WIDTH{1'b0}}};
    localparam logic [DATA_WIDTH:0] TOL = (DATA_WIDTH + 1)'(SYM_TOL);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CAPTURE = 2'd1,
        S_CALC    = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t                state_q,     state_d;
    logic [8:0]            idx_q,       idx_d;
    logic [SUM_W-1:0]      sum0_q,      sum0_d;
    logic [SUM_W-1:0]      sum1_q,      sum1_d;
    logic [DATA_WIDTH-1:0] amplitude_q, amplitude_d;
    logic                  sel_q,       sel_d;
    logic [DATA_WIDTH:0]   sym_err_q,   sym_err_d;
    logic                  mismatch_q,  mismatch_d;
    logic                  busy_q,      busy_d;
    logic                  done_q,      done_d;

    logic [DATA_WIDTH-1:0] m0_s;
    logic [DATA_WIDTH-1:0] m1_s;
    logic [DATA_WIDTH:0]   msum_s;
    logic [DATA_WIDTH:0]   err_s;

    // Half-frame means and symmetry error, evaluated from the settled sums.
    always_comb begin
        m0_s   = sum0_q[SUM_W-1:8];
        m1_s   = sum1_q[SUM_W-1:8];
        // Widened by one bit so 255 + 255 = 510 is not truncated.
        msum_s = {1'b0, m0_s} + {1'b0, m1_s};
        if (msum_s >= MID) begin
            err_s = msum_s - MID;
        end else begin
            err_s = MID - msum_s;
        end
    end

    // Next-state, datapath and registered-output computation.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        sum0_d      = sum0_q;
        sum1_d      = sum1_q;
        amplitude_d = amplitude_q;
        sel_d       = sel_q;
        sym_err_d   = sym_err_q;
        mismatch_d  = mismatch_q;

        case (state_q)
            S_IDLE: begin
                // A sample presented together with start is not accepted.
                if (start) begin
                    state_d = S_CAPTURE;
                    idx_d   = 9'd0;
                    sum0_d  = '0;
                    sum1_d  = '0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_CAPTURE: begin
                if (start) begin
                    // Restart wins over any sample in the same cycle.
                    idx_d  = 9'd0;
                    sum0_d = '0;
                    sum1_d = '0;
                end else if (din_valid) begin
                    if (idx_q[8] == 1'b0) begin
                        sum0_d = sum0_q + SUM_W'(din);
                    end else begin
                        sum1_d = sum1_q + SUM_W'(din);
                    end
                    idx_d = idx_q + 9'd1;
                    if (idx_q == 9'd511) begin
                        state_d = S_CALC;
                    end else begin
                        state_d = S_CAPTURE;
                    end
                end else begin
                    state_d = S_CAPTURE;
                end
            end
            S_CALC: begin
                state_d = S_DONE;
                // Tie resolves to first-half polarity.
                if (m1_s > m0_s) begin
                    sel_d       = 1'b1;
                    amplitude_d = m1_s;
                end else begin
                    sel_d       = 1'b0;
                    amplitude_d = m0_s;
                end
                sym_err_d  = err_s;
                mismatch_d = (err_s > TOL);
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Status outputs registered so they line up with the state they describe.
        busy_d = (state_d == S_CAPTURE) || (state_d == S_CALC);
        done_d = (state_d == S_DONE);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            idx_q       <= 9'd0;
            sum0_q      <= '0;
            sum1_q      <= '0;
            amplitude_q <= '0;
            sel_q       <= 1'b0;
            sym_err_q   <= '0;
            mismatch_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            sum0_q      <= sum0_d;
            sum1_q      <= sum1_d;
            amplitude_q <= amplitude_d;
            sel_q       <= sel_d;
            sym_err_q   <= sym_err_d;
            mismatch_q  <= mismatch_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign amplitude  = amplitude_q;
    assign sel_signal = sel_q;
    assign sym_err    = sym_err_q;
    assign mismatch   = mismatch_q;

endmodule

// File: tb/tb_sqr_param_extract.sv
// -----------------------------------------------------------------------------
// tb_sqr_param_extract
//   Directed table-driven bench for sqr_param_extract (DATA_WIDTH=8,
//   SYM_TOL=4) plus hand-written sequences for abort, start-in-CALC and
//   asynchronous reset mid-capture.
// -----------------------------------------------------------------------------
module tb_sqr_param_extract;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       din_valid = 1'b0;
    logic [7:0] din = 8'd0;
    logic       busy;
    logic       done;
    logic [7:0] amplitude;
    logic       sel_signal;
    logic [8:0] sym_err;
    logic       mismatch;

    int checks = 0;
    int failures = 0;

    sqr_param_extract #(.DATA_WIDTH(8), .SYM_TOL(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .din_valid  (din_valid),
        .din        (din),
        .busy       (busy),
        .done       (done),
        .amplitude  (amplitude),
        .sel_signal (sel_signal),
        .sym_err    (sym_err),
        .mismatch   (mismatch)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a0;
        logic [7:0] a1;
        bit         gap;
        logic [7:0] amp;
        logic       sel;
        logic [8:0] err;
        logic       mis;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Start pulse with a simultaneous valid sample that must be ignored.
    task automatic pulse_start();
        start = 1'b1;
        din_valid = 1'b1;
        din = 8'd255;
        step();
        start = 1'b0;
        din_valid = 1'b0;
    endtask

    // Feed n samples (first 256 = a0, rest = a1), optionally idling every third cycle.
    task automatic feed(input int n, input logic [7:0] a0, input logic [7:0] a1,
                        input bit gap, inout int seen_done, inout int busy_bad);
        int k = 0;
        int c = 0;
        while (k < n) begin
            if (gap && (c % 3 == 2)) begin
                din_valid = 1'b0;
                din = 8'd255;
            end else begin
                din_valid = 1'b1;
                din = (k < 256) ? a0 : a1;
                k++;
            end
            step();
            c++;
            if (busy !== 1'b1) busy_bad++;
            if (done !== 1'b0) seen_done++;
        end
        din_valid = 1'b0;
    endtask

    // From the CALC cycle: check done timing and results.
    task automatic check_result(input string tag, input logic [7:0] amp, input logic sel,
                                input logic [8:0] err, input logic mis);
        chk({tag, "_calc_done"}, done, 1'b0);
        chk({tag, "_calc_busy"}, busy, 1'b1);
        step();
        chk({tag, "_done"}, done, 1'b1);
        chk({tag, "_busy_in_done"}, busy, 1'b0);
        chk({tag, "_amp"}, amplitude, amp);
        chk({tag, "_sel"}, sel_signal, sel);
        chk({tag, "_err"}, sym_err, err);
        chk({tag, "_mis"}, mismatch, mis);
        step();
        chk({tag, "_done_after"}, done, 1'b0);
        chk({tag, "_amp_hold"}, amplitude, amp);
    endtask

    initial begin
        int sd;
        int bb;

        vecs[0] = '{a0: 8'd200, a1: 8'd56,  gap: 1'b0, amp: 8'd200, sel: 1'b0, err: 9'd0,   mis: 1'b0};
        vecs[1] = '{a0: 8'd76,  a1: 8'd180, gap: 1'b0, amp: 8'd180, sel: 1'b1, err: 9'd0,   mis: 1'b0};
        vecs[2] = '{a0: 8'd100, a1: 8'd100, gap: 1'b0, amp: 8'd100, sel: 1'b0, err: 9'd56,  mis: 1'b1};
        vecs[3] = '{a0: 8'd130, a1: 8'd130, gap: 1'b0, amp: 8'd130, sel: 1'b0, err: 9'd4,   mis: 1'b0};
        vecs[4] = '{a0: 8'd200, a1: 8'd56,  gap: 1'b1, amp: 8'd200, sel: 1'b0, err: 9'd0,   mis: 1'b0};
        vecs[5] = '{a0: 8'd255, a1: 8'd255, gap: 1'b0, amp: 8'd255, sel: 1'b0, err: 9'd254, mis: 1'b1};
        vecs[6] = '{a0: 8'd0,   a1: 8'd0,   gap: 1'b0, amp: 8'd0,   sel: 1'b0, err: 9'd256, mis: 1'b1};
        vecs[7] = '{a0: 8'd128, a1: 8'd128, gap: 1'b0, amp: 8'd128, sel: 1'b0, err: 9'd0,   mis: 1'b0};
        vecs[8] = '{a0: 8'd10,  a1: 8'd13,  gap: 1'b1, amp: 8'd13,  sel: 1'b1, err: 9'd233, mis: 1'b1};
        vecs[9] = '{a0: 8'd126, a1: 8'd135, gap: 1'b0, amp: 8'd135, sel: 1'b1, err: 9'd5,   mis: 1'b1};

        // Reset state.
        #12;
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_amp", amplitude, 8'd0);
        chk("rst_sel", sel_signal, 1'b0);
        chk("rst_err", sym_err, 9'd0);
        chk("rst_mis", mismatch, 1'b0);
        rst_n = 1'b1;
        // Valid data in IDLE is ignored.
        din_valid = 1'b1;
        din = 8'd99;
        repeat (3) step();
        din_valid = 1'b0;
        chk("idle_busy", busy, 1'b0);

        for (int i = 0; i < 10; i++) begin
            sd = 0;
            bb = 0;
            pulse_start();
            feed(512, vecs[i].a0, vecs[i].a1, vecs[i].gap, sd, bb);
            chk($sformatf("v%0d_busy_capture", i), bb, 0);
            chk($sformatf("v%0d_no_early_done", i), sd, 0);
            check_result($sformatf("v%0d", i), vecs[i].amp, vecs[i].sel, vecs[i].err, vecs[i].mis);
            repeat (2) step();
        end

        // Abort after 300 samples, then a full frame: one done, fresh results.
        sd = 0;
        bb = 0;
        pulse_start();
        feed(300, 8'd255, 8'd255, 1'b0, sd, bb);
        pulse_start();
        if (done !== 1'b0) sd++;
        feed(512, 8'd76, 8'd180, 1'b0, sd, bb);
        chk("abort_no_done", sd, 0);
        chk("abort_busy", bb, 0);
        check_result("abort", 8'd180, 1'b1, 9'd0, 1'b0);

        // Start pulsed during CALC is ignored.
        sd = 0;
        bb = 0;
        pulse_start();
        feed(512, 8'd200, 8'd56, 1'b0, sd, bb);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("calc_start_done", done, 1'b1);
        chk("calc_start_amp", amplitude, 8'd200);
        step();
        chk("calc_start_idle_busy", busy, 1'b0);
        repeat (3) step();
        chk("calc_start_still_idle", busy, 1'b0);

        // Asynchronous reset after 400 samples.
        sd = 0;
        bb = 0;
        pulse_start();
        feed(400, 8'd76, 8'd180, 1'b0, sd, bb);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", busy, 1'b0);
        chk("arst_amp", amplitude, 8'd0);
        chk("arst_err", sym_err, 9'd0);
        chk("arst_done", done, 1'b0);
        step();
        rst_n = 1'b1;
        din_valid = 1'b1;
        din = 8'd180;
        sd = 0;
        for (int c = 0; c < 600; c++) begin
            step();
            if (done !== 1'b0) sd++;
        end
        din_valid = 1'b0;
        chk("arst_no_done_after", sd, 0);
        chk("arst_idle_busy", busy, 1'b0);

        // New full frame after reset works.
        sd = 0;
        bb = 0;
        pulse_start();
        feed(512, 8'd76, 8'd180, 1'b0, sd, bb);
        check_result("post_rst", 8'd180, 1'b1, 9'd0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
